// File: rtl/irq_ack_sequencer.sv
// irq_ack_sequencer: CPU-side 8086-style two-pulse INTA initiator with bus lock.
// Runs LOCK -> PULSE1 -> GAP -> PULSE2 -> DONE once per request level and
// hands the vector captured during pulse 2 to the core with a one-cycle strobe.
module irq_ack_sequencer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intr,
  input  logic       irq_enable,
  input  logic       ack_request,
  output logic       irq_pending,
  output logic       inta_n,
  output logic       lock_n,
  input  logic [7:0] pic_data,
  input  logic       pic_data_oe_n,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       vector_error,
  output logic       busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOCK   = 3'd1,
    S_PULSE1 = 3'd2,
    S_GAP    = 3'd3,
    S_PULSE2 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             captured;
  logic             accept;
  logic             sample;

  // Start condition: idle, core at a boundary, interrupt live, and request re-armed.
  assign accept = (state == S_IDLE) & ack_request & irq_enable & intr & armed;

  // PIC is driving the vector bus during the second pulse.
  assign sample = (state == S_PULSE2) & ~pic_data_oe_n;

  // Sequencer state, pulse timer and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      armed        <= 1'b1;
      captured     <= 1'b0;
      irq_pending  <= 1'b0;
      inta_n       <= 1'b1;
      lock_n       <= 1'b1;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      vector_error <= 1'b0;
      busy         <= 1'b0;
    end else begin
      irq_pending  <= intr & irq_enable;
      vector_valid <= 1'b0;
      vector_error <= 1'b0;

      // One request level yields one sequence; a released request re-arms.
      if (!ack_request) begin
        armed <= 1'b1;
      end else if (accept) begin
        armed <= 1'b0;
      end

      // Every sampled edge in pulse 2 overwrites, so the last sample wins.
      if (sample) begin
        vector   <= pic_data;
        captured <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_LOCK;
            busy     <= 1'b1;
            lock_n   <= 1'b0;
            captured <= 1'b0;
          end
        end
        S_LOCK: begin
          state  <= S_PULSE1;
          inta_n <= 1'b0;
          cnt    <= PULSE_LOAD;
        end
        S_PULSE1: begin
          if (cnt == '0) begin
            state  <= S_GAP;
            inta_n <= 1'b1;
            cnt    <= GAP_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state  <= S_PULSE2;
            inta_n <= 1'b0;
            cnt    <= PULSE_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_PULSE2: begin
          if (cnt == '0) begin
            state        <= S_DONE;
            inta_n       <= 1'b1;
            lock_n       <= 1'b1;
            vector_valid <= captured | sample;
            vector_error <= ~(captured | sample);
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          inta_n <= 1'b1;
          lock_n <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
